// File: rtl/counter_pkg.sv
// ============================================================================
//  Module   : counter_pkg
//  Purpose  : Shared constants and types for the up/down counter family.
//             Direction and mode encodings, plus the next-state result
//             record carried between the step ALU and the counter register.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_pkg;

  // Direction encoding for the up_down input.
  localparam logic CNT_DIR_UP    = 1'b1;
  localparam logic CNT_DIR_DOWN  = 1'b0;

  // Range-end behaviour encoding for the sat_mode input.
  localparam logic CNT_MODE_WRAP = 1'b0;
  localparam logic CNT_MODE_SAT  = 1'b1;

  // Storage width of the next-value field. Counters narrower than this keep
  // their value zero-extended in the low bits.
  localparam int CNT_RES_W = 32;

  // Next-state result: value plus the two one-cycle event flags.
  typedef struct packed {
    logic [CNT_RES_W-1:0] next;
    logic                 wrap;
    logic                 sat;
  } cnt_result_t;

endpackage : counter_pkg

`default_nettype wire

// File: rtl/updown_step_alu.sv
// ============================================================================
//  Module   : updown_step_alu
//  Purpose  : Combinational next-count computation for one enabled step.
//             Handles up/down direction and wrap/saturate range ends over
//             the range 0..MAX_VAL using a WIDTH+1 bit intermediate.
//  Ports    : i_counter  - current count (assumed <= MAX_VAL)
//             i_eff_step - step already clamped to <= MAX_VAL
//             i_up_down  - 1 = up, 0 = down
//             i_sat_mode - 1 = saturate, 0 = wrap modulo MAX_VAL+1
//             o_next     - next count
//             o_wrap     - this step wrapped past a range end
//             o_sat      - this step was clamped at a range end
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_step_alu
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic [WIDTH-1:0] i_counter,
  input  logic [WIDTH-1:0] i_eff_step,
  input  logic             i_up_down,
  input  logic             i_sat_mode,
  output logic [WIDTH-1:0] o_next,
  output logic             o_wrap,
  output logic             o_sat
);

  localparam logic [WIDTH:0]   c_max_ext = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   c_mod_ext = (WIDTH+1)'(MAX_VAL + 1);
  localparam logic [WIDTH-1:0] c_max     = WIDTH'(MAX_VAL);

  logic [WIDTH:0] w_cnt_ext;
  logic [WIDTH:0] w_step_ext;
  logic [WIDTH:0] w_sum;
  logic           w_over;
  logic           w_under;

  assign w_cnt_ext  = {1'b0, i_counter};
  assign w_step_ext = {1'b0, i_eff_step};
  assign w_sum      = w_cnt_ext + w_step_ext;
  // The extra bit lets the sum exceed 2**WIDTH-1 without losing the carry.
  assign w_over     = (w_sum > c_max_ext);
  assign w_under    = (w_step_ext > w_cnt_ext);

  always_comb begin
    o_next = i_counter;
    o_wrap = 1'b0;
    o_sat  = 1'b0;
    case (i_up_down)
      CNT_DIR_UP: begin
        if (w_over) begin
          if (i_sat_mode == CNT_MODE_SAT) begin
            o_next = c_max;
            o_sat  = 1'b1;
          end else begin
            o_next = WIDTH'(w_sum - c_mod_ext);
            o_wrap = 1'b1;
          end
        end else begin
          o_next = WIDTH'(w_sum);
        end
      end
      CNT_DIR_DOWN: begin
        if (w_under) begin
          if (i_sat_mode == CNT_MODE_SAT) begin
            o_next = '0;
            o_sat  = 1'b1;
          end else begin
            // counter + modulus fits in WIDTH+1 bits since both are <= MAX_VAL+1.
            o_next = WIDTH'(w_cnt_ext + c_mod_ext - w_step_ext);
            o_wrap = 1'b1;
          end
        end else begin
          o_next = i_counter - i_eff_step;
        end
      end
      default: ;
    endcase
  end

endmodule : updown_step_alu

`default_nettype wire

// File: rtl/updown_counter_param.sv
// ============================================================================
//  Module   : updown_counter_param
//  Purpose  : Parametrised up/down counter with programmable modulus,
//             variable step, synchronous load, count enable, runtime
//             wrap/saturate mode and range-end flags.
//  Ports    : clk, reset (sync, active-high), en, up_down, step, sat_mode,
//             load, load_value -> counter, wrap, sat, at_max, at_min
//             With CNT_CMP_EN defined: cmp_value -> match (registered).
//  Config   : `define CNT_CMP_EN to add the compare-match feature.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_counter_param
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic [WIDTH-1:0] step,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] counter,
  output logic             wrap,
  output logic             sat,
  output logic             at_max,
  output logic             at_min
`ifdef CNT_CMP_EN
  ,
  input  logic [WIDTH-1:0] cmp_value,
  output logic             match
`endif
);

  localparam logic [WIDTH:0]       c_max_ext = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0]     c_max     = WIDTH'(MAX_VAL);
  localparam logic [CNT_RES_W-1:0] c_max_res = CNT_RES_W'(MAX_VAL);

  cnt_result_t      r_state;
  cnt_result_t      w_state_d;
  cnt_result_t      w_count_res;
  logic [WIDTH-1:0] w_eff_step;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_alu_next;
  logic             w_alu_wrap;
  logic             w_alu_sat;

  // Clamp step and load value into the legal range before use.
  assign w_eff_step = ({1'b0, step} > c_max_ext)       ? c_max : step;
  assign w_load_val = ({1'b0, load_value} > c_max_ext) ? c_max : load_value;

  updown_step_alu #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_alu (
    .i_counter  (counter),
    .i_eff_step (w_eff_step),
    .i_up_down  (up_down),
    .i_sat_mode (sat_mode),
    .o_next     (w_alu_next),
    .o_wrap     (w_alu_wrap),
    .o_sat      (w_alu_sat)
  );

  always_comb begin
    w_count_res      = '0;
    w_count_res.next = CNT_RES_W'(w_alu_next);
    w_count_res.wrap = w_alu_wrap;
    w_count_res.sat  = w_alu_sat;
  end

  // Load beats count; an idle cycle holds the value and drops both pulses.
  always_comb begin
    w_state_d      = r_state;
    w_state_d.wrap = 1'b0;
    w_state_d.sat  = 1'b0;
    if (load) begin
      w_state_d.next = CNT_RES_W'(w_load_val);
    end else if (en) begin
      w_state_d = w_count_res;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= '0;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Upper bits of the stored value are always zero, so whole-field
  // compares are equivalent to WIDTH-bit compares.
  assign counter = r_state.next[WIDTH-1:0];
  assign wrap    = r_state.wrap;
  assign sat     = r_state.sat;
  assign at_max  = (r_state.next == c_max_res);
  assign at_min  = (r_state.next == '0);

`ifdef CNT_CMP_EN
  // r_upd marks that the current counter value arrived via a load or a
  // non-zero enabled step, so a merely held value does not re-trigger.
  logic r_upd;
  logic r_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_upd   <= 1'b0;
      r_match <= 1'b0;
    end else begin
      r_upd   <= load | (en & (w_eff_step != '0));
      r_match <= r_upd & (counter == cmp_value);
    end
  end

  assign match = r_match;
`endif

endmodule : updown_counter_param

`default_nettype wire

// File: tb/tb_updown_counter_param.sv
// ============================================================================
//  Module   : tb_updown_counter_param
//  Purpose  : Directed self-checking bench. Two counters share stimulus:
//             one full-range (MAX_VAL=15) and one decade (MAX_VAL=9).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_updown_counter_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       up_down = 1'b1;
  logic [3:0] step = 4'd0;
  logic       sat_mode = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = 4'd0;

  logic [3:0] cnt15, cnt9;
  logic       wrap15, wrap9, sat15, sat9;
  logic       amax15, amax9, amin15, amin9;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

`ifdef CNT_CMP_EN
  logic [3:0] cmp_value = 4'd6;
  logic       match15, match9;
`endif

  updown_counter_param #(.WIDTH(4), .MAX_VAL(15)) u_dut15 (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .step(step),
    .sat_mode(sat_mode), .load(load), .load_value(load_value),
    .counter(cnt15), .wrap(wrap15), .sat(sat15), .at_max(amax15), .at_min(amin15)
`ifdef CNT_CMP_EN
    , .cmp_value(cmp_value), .match(match15)
`endif
  );

  updown_counter_param #(.WIDTH(4), .MAX_VAL(9)) u_dut9 (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .step(step),
    .sat_mode(sat_mode), .load(load), .load_value(load_value),
    .counter(cnt9), .wrap(wrap9), .sat(sat9), .at_max(amax9), .at_min(amin9)
`ifdef CNT_CMP_EN
    , .cmp_value(cmp_value), .match(match9)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check counter plus both pulses of one instance.
  task automatic chk3(input string tag, input logic [3:0] c, input logic w, input logic s,
                      input logic [3:0] ec, input logic ew, input logic es);
    check_val({tag, ".cnt"},  {28'd0, c}, {28'd0, ec});
    check_val({tag, ".wrap"}, {31'd0, w}, {31'd0, ew});
    check_val({tag, ".sat"},  {31'd0, s}, {31'd0, es});
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1; load_value = v;
    tick();
    load = 1'b0;
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    tick(); tick();
    chk3("rst15", cnt15, wrap15, sat15, 4'd0, 1'b0, 1'b0);
    chk3("rst9",  cnt9,  wrap9,  sat9,  4'd0, 1'b0, 1'b0);
    check_val("rst15.at_min", {31'd0, amin15}, 32'd1);
    check_val("rst15.at_max", {31'd0, amax15}, 32'd0);
`ifdef CNT_CMP_EN
    check_val("rst15.match", {31'd0, match15}, 32'd0);
`endif

    // Count up by 1 for 16 cycles, wrap mode
    reset = 1'b0; en = 1'b1; up_down = 1'b1; step = 4'd1; sat_mode = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk3($sformatf("up15[%0d]", i), cnt15, wrap15, sat15, 4'(i % 16), (i == 16), 1'b0);
      check_val($sformatf("up15.at_max[%0d]", i), {31'd0, amax15}, {31'd0, (i == 15)});
      chk3($sformatf("up9[%0d]", i), cnt9, wrap9, sat9, 4'(i % 10), (i == 10), 1'b0);
    end

    // Down by 3 from 1, wrap mode (load with en=1 still loads)
    do_load(4'd1);
    chk3("ld1_15", cnt15, wrap15, sat15, 4'd1, 1'b0, 1'b0);
    up_down = 1'b0; step = 4'd3;
    tick();
    chk3("dn9a", cnt9, wrap9, sat9, 4'd8, 1'b1, 1'b0);
    chk3("dn15a", cnt15, wrap15, sat15, 4'd14, 1'b1, 1'b0);
    tick();
    chk3("dn9b", cnt9, wrap9, sat9, 4'd5, 1'b0, 1'b0);
    chk3("dn15b", cnt15, wrap15, sat15, 4'd11, 1'b0, 1'b0);

    // Saturate up by 4 from 7
    do_load(4'd7);
    sat_mode = 1'b1; up_down = 1'b1; step = 4'd4;
    tick();
    chk3("sat9a", cnt9, wrap9, sat9, 4'd9, 1'b0, 1'b1);
    check_val("sat9a.at_max", {31'd0, amax9}, 32'd1);
    chk3("sat15a", cnt15, wrap15, sat15, 4'd11, 1'b0, 1'b0);
    tick();
    chk3("sat9b", cnt9, wrap9, sat9, 4'd9, 1'b0, 1'b1);
    chk3("sat15b", cnt15, wrap15, sat15, 4'd15, 1'b0, 1'b0);
    tick();
    chk3("sat15c", cnt15, wrap15, sat15, 4'd15, 1'b0, 1'b1);
    do_load(4'd7);
    step = 4'd2;
    tick();
    chk3("sat9exact", cnt9, wrap9, sat9, 4'd9, 1'b0, 1'b0);
    chk3("sat15d", cnt15, wrap15, sat15, 4'd9, 1'b0, 1'b0);

    // Load clamp, and step clamp in wrap mode
    do_load(4'd12);
    chk3("ld12_9", cnt9, wrap9, sat9, 4'd9, 1'b0, 1'b0);
    check_val("ld12_15.cnt", {28'd0, cnt15}, 32'd12);
    do_load(4'd0);
    sat_mode = 1'b0; up_down = 1'b1; step = 4'd13;
    tick();
    chk3("stp13_9", cnt9, wrap9, sat9, 4'd9, 1'b0, 1'b0);
    chk3("stp13_15", cnt15, wrap15, sat15, 4'd13, 1'b0, 1'b0);

    // Reset together with load while counting at 5
    do_load(4'd5);
    step = 4'd1;
    reset = 1'b1; load = 1'b1; load_value = 4'd3;
    tick();
    reset = 1'b0; load = 1'b0;
    chk3("rstld9", cnt9, wrap9, sat9, 4'd0, 1'b0, 1'b0);
    check_val("rstld9.at_min", {31'd0, amin9}, 32'd1);
    check_val("rstld15.cnt", {28'd0, cnt15}, 32'd0);

    // Saturate down at 0: holds with sat every cycle, idle clears the pulse
    sat_mode = 1'b1; up_down = 1'b0; step = 4'd2;
    tick();
    chk3("satdn9a", cnt9, wrap9, sat9, 4'd0, 1'b0, 1'b1);
    tick();
    chk3("satdn9b", cnt9, wrap9, sat9, 4'd0, 1'b0, 1'b1);
    en = 1'b0;
    tick();
    chk3("idle9", cnt9, wrap9, sat9, 4'd0, 1'b0, 1'b0);

    // Wrap pulse clears on the following non-wrapping step
    en = 1'b1; sat_mode = 1'b0; up_down = 1'b1; step = 4'd1;
    do_load(4'd9);
    tick();
    chk3("wr9a", cnt9, wrap9, sat9, 4'd0, 1'b1, 1'b0);
    tick();
    chk3("wr9b", cnt9, wrap9, sat9, 4'd1, 1'b0, 1'b0);

`ifdef CNT_CMP_EN
    // Compare: cmp_value=6, counting up from 4
    cmp_value = 4'd6;
    do_load(4'd4);
    tick();
    check_val("cmp.cnt5", {28'd0, cnt15}, 32'd5);
    check_val("cmp.m5", {31'd0, match15}, 32'd0);
    tick();
    check_val("cmp.cnt6", {28'd0, cnt15}, 32'd6);
    check_val("cmp.m6", {31'd0, match15}, 32'd0);
    tick();
    check_val("cmp.m7", {31'd0, match15}, 32'd1);
    check_val("cmp9.m7", {31'd0, match9}, 32'd1);
    tick();
    check_val("cmp.m8", {31'd0, match15}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_updown_counter_param

`default_nettype wire
